vexriscv_bus_arbiter: RTL and testbench

// - Merges VexRiscv simple iBus and dBus onto one single-outstanding memory port.
// - Round-robin grant, one transaction in flight; write responses swallowed; response timeout.
// - Sits between the VexRiscv core and the shared memory model / formal memory stub.

---
 rtl/vexriscv_bus_pkg.sv | 31 +++
 rtl/vexriscv_bus_timeout.sv | 32 +++
 rtl/vexriscv_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_vexriscv_bus_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vexriscv_bus_pkg.sv
// rtl/vexriscv_bus_pkg.sv - shared types and helpers for the VexRiscv bus arbiter
// Purpose: arbiter FSM state encoding, latched memory command record, byte-lane helper.
// Ports: none (package).
package vexriscv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RSP  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } mem_cmd_t;

  // Byte-lane enables for a store of the given size at the given low address bits.
  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr_lo;
      2'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/vexriscv_bus_timeout.sv
// rtl/vexriscv_bus_timeout.sv - response wait counter with expiry flag
// Purpose: counts cycles spent waiting for a memory response and flags expiry.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   clear         - force the count to zero (held while not waiting)
//   enable        - count this cycle (waiting, no response seen)
//   expired       - count has reached TIMEOUT
module vexriscv_bus_timeout #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Saturates at TIMEOUT so expiry stays asserted until the owner clears it.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/vexriscv_bus_arbiter.sv
// rtl/vexriscv_bus_arbiter.sv - round-robin merge of VexRiscv iBus/dBus onto one memory port
// Purpose: grants one of iBus/dBus (round-robin on contention), issues a single
//   outstanding memory command, returns load/fetch responses to the owner, swallows
//   store responses, and forces an error response when memory does not answer.
// Ports:
//   clock, reset                         - clock, synchronous active-high reset
//   iBus_cmd_* / iBus_rsp_*              - instruction fetch command and response
//   dBus_cmd_* / dBus_rsp_*              - data load/store command and load response
//   mem_cmd_* / mem_rsp_*                - shared memory request/response port
//   stray_rsp                            - memory response arriving when none is awaited
module vexriscv_bus_arbiter
  import vexriscv_bus_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iBus_cmd_valid,
  output logic        iBus_cmd_ready,
  input  logic [31:0] iBus_cmd_payload_pc,
  output logic        iBus_rsp_ready,
  output logic [31:0] iBus_rsp_inst,
  output logic        iBus_rsp_error,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic        dBus_cmd_payload_wr,
  input  logic [31:0] dBus_cmd_payload_address,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [1:0]  dBus_cmd_payload_size,
  output logic        dBus_rsp_ready,
  output logic [31:0] dBus_rsp_data,
  output logic        dBus_rsp_error,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_cmd_addr,
  output logic        mem_cmd_wr,
  output logic [31:0] mem_cmd_wdata,
  output logic [3:0]  mem_cmd_wstrb,
  output logic        mem_cmd_instr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  input  logic        mem_rsp_error,
  output logic        stray_rsp
);

  arb_state_t state, state_next;
  mem_cmd_t   cmd_q, grant_cmd;
  logic       last_i;     // 1 when the most recent grant went to iBus
  logic       grant_i, grant_d;
  logic       in_cmd, in_rsp, rsp_done, expired;
  logic       unused_pc_lo;

  assign unused_pc_lo = ^iBus_cmd_payload_pc[1:0];

  // Grants only happen in IDLE; on contention the side not served last wins.
  assign grant_i = (state == IDLE) && !reset && iBus_cmd_valid && (!dBus_cmd_valid || !last_i);
  assign grant_d = (state == IDLE) && !reset && dBus_cmd_valid && !grant_i;

  assign in_cmd   = (state == CMD) && !reset;
  assign in_rsp   = (state == RSP) && !reset;
  // A real response in the expiry cycle takes priority over the forced error.
  assign rsp_done = in_rsp && (mem_rsp_valid || expired);

  vexriscv_bus_timeout #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != RSP),
    .enable ((state == RSP) && !mem_rsp_valid),
    .expired(expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_i || grant_d) state_next = CMD;
      CMD:     if (mem_cmd_ready) state_next = RSP;
      RSP:     if (mem_rsp_valid || expired) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_cmd = '0;
    if (grant_i) begin
      grant_cmd.addr  = {iBus_cmd_payload_pc[31:2], 2'b00};
      grant_cmd.instr = 1'b1;
    end else if (grant_d) begin
      grant_cmd.addr  = {dBus_cmd_payload_address[31:2], 2'b00};
      grant_cmd.wr    = dBus_cmd_payload_wr;
      grant_cmd.wdata = dBus_cmd_payload_wr ? dBus_cmd_payload_data : 32'h0;
      grant_cmd.wstrb = dBus_cmd_payload_wr ?
                        size_to_wstrb(dBus_cmd_payload_size, dBus_cmd_payload_address[1:0]) : 4'b0000;
    end
  end

  // The latched command also records the owner (instr) for routing the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_q  <= '0;
      last_i <= 1'b0;
    end else if (grant_i || grant_d) begin
      cmd_q  <= grant_cmd;
      last_i <= grant_i;
    end
  end

  always_comb begin
    iBus_rsp_ready = 1'b0;
    iBus_rsp_inst  = 32'h0;
    iBus_rsp_error = 1'b0;
    dBus_rsp_ready = 1'b0;
    dBus_rsp_data  = 32'h0;
    dBus_rsp_error = 1'b0;
    // Store responses are consumed here and never reach the core.
    if (rsp_done && !cmd_q.wr) begin
      if (cmd_q.instr) begin
        iBus_rsp_ready = 1'b1;
        iBus_rsp_inst  = mem_rsp_valid ? mem_rsp_rdata : 32'h0;
        iBus_rsp_error = mem_rsp_valid ? mem_rsp_error : 1'b1;
      end else begin
        dBus_rsp_ready = 1'b1;
        dBus_rsp_data  = mem_rsp_valid ? mem_rsp_rdata : 32'h0;
        dBus_rsp_error = mem_rsp_valid ? mem_rsp_error : 1'b1;
      end
    end
  end

  assign iBus_cmd_ready = grant_i;
  assign dBus_cmd_ready = grant_d;

  assign mem_cmd_valid = in_cmd;
  assign mem_cmd_addr  = cmd_q.addr;
  assign mem_cmd_wr    = cmd_q.wr;
  assign mem_cmd_wdata = cmd_q.wdata;
  assign mem_cmd_wstrb = cmd_q.wstrb;
  assign mem_cmd_instr = cmd_q.instr;

  // Responses outside RSP (e.g. after a timeout or reset) are dropped but flagged.
  assign stray_rsp = mem_rsp_valid && !in_rsp;

endmodule

// File: tb/tb_vexriscv_bus_arbiter.sv
// tb/tb_vexriscv_bus_arbiter.sv - scoreboard testbench for vexriscv_bus_arbiter
`timescale 1ns/1ps
module tb_vexriscv_bus_arbiter;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        iBus_cmd_valid, iBus_cmd_ready;
  logic [31:0] iBus_cmd_payload_pc;
  logic        iBus_rsp_ready, iBus_rsp_error;
  logic [31:0] iBus_rsp_inst;
  logic        dBus_cmd_valid, dBus_cmd_ready, dBus_cmd_payload_wr;
  logic [31:0] dBus_cmd_payload_address, dBus_cmd_payload_data;
  logic [1:0]  dBus_cmd_payload_size;
  logic        dBus_rsp_ready, dBus_rsp_error;
  logic [31:0] dBus_rsp_data;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_wr, mem_cmd_instr;
  logic [31:0] mem_cmd_addr, mem_cmd_wdata;
  logic [3:0]  mem_cmd_wstrb;
  logic        mem_rsp_valid, mem_rsp_error;
  logic [31:0] mem_rsp_rdata;
  logic        stray_rsp;

  vexriscv_bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .iBus_cmd_valid(iBus_cmd_valid), .iBus_cmd_ready(iBus_cmd_ready),
    .iBus_cmd_payload_pc(iBus_cmd_payload_pc),
    .iBus_rsp_ready(iBus_rsp_ready), .iBus_rsp_inst(iBus_rsp_inst), .iBus_rsp_error(iBus_rsp_error),
    .dBus_cmd_valid(dBus_cmd_valid), .dBus_cmd_ready(dBus_cmd_ready),
    .dBus_cmd_payload_wr(dBus_cmd_payload_wr), .dBus_cmd_payload_address(dBus_cmd_payload_address),
    .dBus_cmd_payload_data(dBus_cmd_payload_data), .dBus_cmd_payload_size(dBus_cmd_payload_size),
    .dBus_rsp_ready(dBus_rsp_ready), .dBus_rsp_data(dBus_rsp_data), .dBus_rsp_error(dBus_rsp_error),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_wr(mem_cmd_wr), .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_wstrb(mem_cmd_wstrb),
    .mem_cmd_instr(mem_cmd_instr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_error(mem_rsp_error),
    .stray_rsp(stray_rsp)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } exp_cmd_t;

  typedef struct {
    logic        is_i;
    logic [31:0] data;
    logic        err;
  } exp_rsp_t;

  exp_cmd_t exp_cmds[$];
  exp_rsp_t exp_rsps[$];
  logic     grant_log[$];

  int   checks = 0, failures = 0;
  int   cyc = 0, grant_cyc = 0, rsp_cnt = 0, stray_cnt = 0;
  int   exp_lat = 0;     // expected grant->response cycles, 0 = not checked
  int   exp_mode = 0;    // 0 normal response, 1 forced timeout error, 2 no response
  int   rsp_delay = 0;   // memory answers this many cycles into RSP
  logic rsp_drop = 1'b0, rsp_err_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'hDEAD_0000);
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [1:0] lo);
    if (size == 2'd0) begin
      case (lo)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (size == 2'd1) return (lo >= 2'd2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_rsp(input logic is_i, input logic [31:0] a);
    exp_rsp_t r;
    r.is_i = is_i;
    r.data = mem_word(a);
    r.err  = rsp_err_en;
    if (exp_mode == 1) begin
      r.data = 32'h0;
      r.err  = 1'b1;
    end
    if (exp_mode != 2) exp_rsps.push_back(r);
  endtask

  task automatic ibus_req(input logic [31:0] pc);
    int n;
    logic got;
    exp_cmd_t c;
    iBus_cmd_valid = 1'b1;
    iBus_cmd_payload_pc = pc;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clock);
      got = iBus_cmd_ready;
      n++;
    end
    if (!got) check("ibus_grant_wait", 64'(got), 64'(1));
    else begin
      c.addr = {pc[31:2], 2'b00}; c.wr = 1'b0; c.wdata = 32'h0; c.wstrb = 4'h0; c.instr = 1'b1;
      exp_cmds.push_back(c);
      push_rsp(1'b1, c.addr);
    end
    @(posedge clock);
    #1;
    iBus_cmd_valid = 1'b0;
  endtask

  task automatic dbus_req(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] size);
    int n;
    logic got;
    exp_cmd_t c;
    dBus_cmd_valid = 1'b1;
    dBus_cmd_payload_wr = wr;
    dBus_cmd_payload_address = a;
    dBus_cmd_payload_data = d;
    dBus_cmd_payload_size = size;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clock);
      got = dBus_cmd_ready;
      n++;
    end
    if (!got) check("dbus_grant_wait", 64'(got), 64'(1));
    else begin
      c.addr = {a[31:2], 2'b00}; c.wr = wr; c.wdata = wr ? d : 32'h0;
      c.wstrb = wr ? exp_strb(size, a[1:0]) : 4'h0; c.instr = 1'b0;
      exp_cmds.push_back(c);
      if (!wr) push_rsp(1'b0, c.addr);
    end
    @(posedge clock);
    #1;
    dBus_cmd_valid = 1'b0;
  endtask

  // Memory model: answers each accepted command rsp_delay cycles into RSP.
  initial begin : mem_model
    logic        pend, f;
    int          wait_c;
    logic [31:0] paddr, a;
    pend = 1'b0; wait_c = 0; paddr = 32'h0;
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0; mem_rsp_error = 1'b0;
    forever begin
      @(negedge clock);
      f = mem_cmd_valid && mem_cmd_ready;
      a = mem_cmd_addr;
      @(posedge clock);
      #1;
      mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0; mem_rsp_error = 1'b0;
      if (f && !rsp_drop) begin
        pend = 1'b1; wait_c = rsp_delay; paddr = a;
      end
      if (pend) begin
        if (wait_c == 0) begin
          mem_rsp_valid = 1'b1; mem_rsp_rdata = mem_word(paddr); mem_rsp_error = rsp_err_en;
          pend = 1'b0;
        end else begin
          wait_c--;
        end
      end
    end
  end

  // Monitor: pops the scoreboards as the DUT issues commands and responses.
  always @(negedge clock) begin : monitor
    exp_cmd_t    ec;
    exp_rsp_t    er;
    logic [31:0] rdata;
    logic        rerr;
    cyc++;
    if (!reset) begin
      if (iBus_cmd_ready && dBus_cmd_ready) check("dual_grant", 64'(1), 64'(0));
      if (iBus_cmd_ready || dBus_cmd_ready) begin
        grant_cyc = cyc;
        grant_log.push_back(iBus_cmd_ready);
      end
      if (mem_cmd_valid && mem_cmd_ready) begin
        if (exp_cmds.size() == 0) check("unexpected_cmd", 64'(1), 64'(0));
        else begin
          ec = exp_cmds.pop_front();
          check("cmd_addr", 64'(mem_cmd_addr), 64'(ec.addr));
          check("cmd_wr", 64'(mem_cmd_wr), 64'(ec.wr));
          check("cmd_wdata", 64'(mem_cmd_wdata), 64'(ec.wdata));
          check("cmd_wstrb", 64'(mem_cmd_wstrb), 64'(ec.wstrb));
          check("cmd_instr", 64'(mem_cmd_instr), 64'(ec.instr));
        end
      end
      if (iBus_rsp_ready || dBus_rsp_ready) begin
        rsp_cnt++;
        if (iBus_rsp_ready && dBus_rsp_ready) check("dual_rsp", 64'(1), 64'(0));
        if (exp_rsps.size() == 0) check("unexpected_rsp", 64'(1), 64'(0));
        else begin
          er = exp_rsps.pop_front();
          rdata = er.is_i ? iBus_rsp_inst : dBus_rsp_data;
          rerr  = er.is_i ? iBus_rsp_error : dBus_rsp_error;
          check("rsp_owner", 64'(iBus_rsp_ready), 64'(er.is_i));
          check("rsp_data", 64'(rdata), 64'(er.data));
          check("rsp_error", 64'(rerr), 64'(er.err));
          if (exp_lat != 0) check("rsp_latency", 64'(cyc - grant_cyc), 64'(exp_lat));
        end
      end
      if (stray_rsp) stray_cnt++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin : stimulus
    int s0, r0;
    logic [31:0] st_addr [5];
    logic [1:0]  st_size [5];
    st_addr = '{32'h203, 32'h402, 32'h500, 32'h601, 32'h700};
    st_size = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2};

    reset = 1'b1;
    iBus_cmd_valid = 1'b0; iBus_cmd_payload_pc = 32'h0;
    dBus_cmd_valid = 1'b0; dBus_cmd_payload_wr = 1'b0; dBus_cmd_payload_address = 32'h0;
    dBus_cmd_payload_data = 32'h0; dBus_cmd_payload_size = 2'd0;
    mem_cmd_ready = 1'b1;
    step(3);
    @(negedge clock);
    check("rst_mem_cmd_valid", 64'(mem_cmd_valid), 64'(0));
    check("rst_mem_cmd_addr", 64'(mem_cmd_addr), 64'(0));
    check("rst_mem_cmd_wstrb", 64'(mem_cmd_wstrb), 64'(0));
    check("rst_cmd_ready", 64'({iBus_cmd_ready, dBus_cmd_ready}), 64'(0));
    check("rst_rsp_ready", 64'({iBus_rsp_ready, dBus_rsp_ready}), 64'(0));
    check("rst_stray", 64'(stray_rsp), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single fetch, immediate memory.
    exp_lat = 2;
    r0 = rsp_cnt;
    ibus_req(32'h100);
    step(4);
    check("fetch_rsp_count", 64'(rsp_cnt - r0), 64'(1));

    // Contention after reset: iBus first, then strict alternation.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    grant_log.delete();
    fork
      for (int k = 0; k < 4; k++) ibus_req(32'h1000 + 32'(k * 4));
      for (int k = 0; k < 4; k++) dbus_req(1'b0, 32'h2000 + 32'(k * 4), 32'h0, 2'd2);
    join
    step(6);
    check("rr_grant_count", 64'(grant_log.size()), 64'(8));
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      check("rr_order", 64'(grant_log[k]), 64'(k % 2 == 0));

    // Stores: lanes from size/address, responses swallowed.
    s0 = stray_cnt;
    r0 = rsp_cnt;
    for (int k = 0; k < 5; k++) begin
      dbus_req(1'b1, st_addr[k], 32'hAAAA_AAAA, st_size[k]);
      step(3);
    end
    check("store_no_rsp", 64'(rsp_cnt - r0), 64'(0));
    check("store_no_stray", 64'(stray_cnt - s0), 64'(0));

    // Load with command stalled 5 cycles.
    mem_cmd_ready = 1'b0;
    exp_lat = 7;
    dbus_req(1'b0, 32'h300, 32'h0, 2'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("stall_valid", 64'(mem_cmd_valid), 64'(1));
      check("stall_addr", 64'(mem_cmd_addr), 64'(32'h300));
      check("stall_no_rsp", 64'(dBus_rsp_ready), 64'(0));
      @(posedge clock);
      #1;
    end
    mem_cmd_ready = 1'b1;
    step(4);

    // Timeout, then late response flagged stray.
    exp_mode = 1;
    rsp_delay = TIMEOUT + 3;
    exp_lat = 2 + TIMEOUT;
    s0 = stray_cnt;
    r0 = rsp_cnt;
    dbus_req(1'b0, 32'h800, 32'h0, 2'd2);
    step(TIMEOUT + 10);
    check("timeout_rsp_count", 64'(rsp_cnt - r0), 64'(1));
    check("timeout_stray", 64'(stray_cnt - s0), 64'(1));
    exp_mode = 0;

    // Response just before and exactly at expiry: real data wins.
    for (int k = 0; k < 2; k++) begin
      rsp_delay = TIMEOUT - 1 + k;
      exp_lat = 2 + rsp_delay;
      s0 = stray_cnt;
      dbus_req(1'b0, 32'h900 + 32'(k * 4), 32'h0, 2'd2);
      step(TIMEOUT + 6);
      check("edge_no_stray", 64'(stray_cnt - s0), 64'(0));
    end

    // Store with no memory answer: times out silently, then a fetch with memory error.
    rsp_delay = 0;
    rsp_drop = 1'b1;
    r0 = rsp_cnt;
    dbus_req(1'b1, 32'hA00, 32'h1234_5678, 2'd2);
    step(TIMEOUT + 6);
    rsp_drop = 1'b0;
    check("store_timeout_silent", 64'(rsp_cnt - r0), 64'(0));
    rsp_err_en = 1'b1;
    exp_lat = 2;
    ibus_req(32'hB04);
    step(4);
    rsp_err_en = 1'b0;

    // Reset while waiting in RSP.
    exp_mode = 2;
    exp_lat = 0;
    rsp_delay = 6;
    s0 = stray_cnt;
    r0 = rsp_cnt;
    dbus_req(1'b0, 32'hC00, 32'h0, 2'd2);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clock);
    check("rrsp_mem_valid", 64'(mem_cmd_valid), 64'(0));
    check("rrsp_mem_addr", 64'(mem_cmd_addr), 64'(0));
    check("rrsp_rsp_ready", 64'(dBus_rsp_ready), 64'(0));
    step(8);
    check("rrsp_stray", 64'(stray_cnt - s0), 64'(1));
    check("rrsp_no_rsp", 64'(rsp_cnt - r0), 64'(0));
    exp_mode = 0;
    rsp_delay = 0;
    exp_lat = 2;
    ibus_req(32'h104);
    step(4);

    check("rsp_queue_empty", 64'(exp_rsps.size()), 64'(0));
    check("cmd_queue_empty", 64'(exp_cmds.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
